dma_cmd_arbiter: RTL and testbench

- Shares the single DMA read channel (command plus returning read-data stream) between NUM_REQ user requesters.
- Round-robin arbitrates requester commands onto one registered command output.
- Records the granted requester ID in an in-order tag FIFO.
- Steers each returning read burst, delimited by last, back to the requester that issued it.
- Sits between user-role DMA clients and the DMA interface's read-command and read-data ports, in the user clock domain.

---
 rtl/dma_arb_pkg.sv | 26 ++
 rtl/dma_tag_fifo.sv | 61 ++++++
 rtl/dma_cmd_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dma_cmd_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and defaults for the DMA command arbiters.
// Read side today; the write-side arbiter reuses these types.
package dma_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_OUT_DEF = 16;
  localparam int ADDR_W_DEF  = 64;
  localparam int LEN_W_DEF   = 32;
  localparam int DATA_W      = 512;
  localparam int KEEP_W      = DATA_W / 8;

  localparam int TAG_W = $clog2(NUM_REQ_DEF);
  localparam int PTR_W = $clog2(MAX_OUT_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [LEN_W_DEF-1:0]  len;
  } dma_cmd_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dma_tag_fifo.sv
// In-order requester-tag FIFO; remembers who owns each
// outstanding DMA command until its data has returned.
module dma_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_cmd_arbiter.sv
// Round-robin share of one DMA read channel between requesters;
// return bursts are steered back by an in-order tag FIFO.
module dma_cmd_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUT_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int LEN_W           = LEN_W_DEF,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        s_cmd_valid,
  output logic [NUM_REQ-1:0]        s_cmd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] s_cmd_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  s_cmd_len,
  output logic                      m_cmd_valid,
  input  logic                      m_cmd_ready,
  output logic [ADDR_W-1:0]         m_cmd_addr,
  output logic [LEN_W-1:0]          m_cmd_len,
  input  logic                      s_data_valid,
  output logic                      s_data_ready,
  input  logic [DATA_W-1:0]         s_data_data,
  input  logic [KEEP_W-1:0]         s_data_keep,
  input  logic                      s_data_last,
  output logic [NUM_REQ-1:0]        m_data_valid,
  input  logic [NUM_REQ-1:0]        m_data_ready,
  output logic [DATA_W-1:0]         m_data_data,
  output logic [KEEP_W-1:0]         m_data_keep,
  output logic                      m_data_last,
  output logic [CNT_W-1:0]          outstanding,
  output logic [31:0]               zero_len_drops
);

  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] winner;
  logic [TW-1:0] head;
  logic          found;
  logic          load;
  logic          grant;
  logic          zero_len;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  cmd_t          win_cmd;

  function automatic logic [TW-1:0] rr_idx(
    input logic [TW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end
    return TW'(s);
  endfunction

  // Search starts one past the last winner so every requester
  // gets a turn before anyone is served twice.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && s_cmd_valid[rr_idx(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = rr_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    win_cmd.addr = s_cmd_addr[int'(winner)*ADDR_W +: ADDR_W];
    win_cmd.len  = s_cmd_len[int'(winner)*LEN_W +: LEN_W];
  end

  // Full uses registered occupancy: a pop frees the slot
  // for the following cycle, never the current one.
  assign load     = ~areset & (~m_cmd_valid | m_cmd_ready)
                  & ~full;
  assign grant    = load & found;
  assign zero_len = (win_cmd.len == '0);
  assign push     = grant & ~zero_len;

  always_comb begin
    s_cmd_ready = '0;
    if (grant) begin
      s_cmd_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= winner;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_cmd_valid <= 1'b0;
      m_cmd_addr  <= '0;
      m_cmd_len   <= '0;
    end else if (push) begin
      m_cmd_valid <= 1'b1;
      m_cmd_addr  <= win_cmd.addr;
      m_cmd_len   <= win_cmd.len;
    end else if (m_cmd_valid && m_cmd_ready) begin
      m_cmd_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      zero_len_drops <= '0;
    end else if (grant && zero_len) begin
      zero_len_drops <= sat_inc(zero_len_drops);
    end
  end

  dma_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tags (
    .clk       (aclk),
    .rst       (areset),
    .push      (push),
    .push_data (winner),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

  // Return path: the FIFO head owns the bus until its last beat.
  assign s_data_ready = ~empty & m_data_ready[head];
  assign pop = s_data_valid & s_data_ready & s_data_last;

  always_comb begin
    m_data_valid = '0;
    if (s_data_valid && !empty) begin
      m_data_valid[head] = 1'b1;
    end
  end

  assign m_data_data = s_data_data;
  assign m_data_keep = s_data_keep;
  assign m_data_last = s_data_last;

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// Randomized and directed bench for dma_cmd_arbiter with a
// queue-based reference model checked every cycle.
module tb_dma_cmd_arbiter;
  import dma_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 16;
  localparam int AW   = 64;
  localparam int LW   = 32;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    s_cmd_valid;
  logic [N-1:0]    s_cmd_ready;
  logic [N*AW-1:0] s_cmd_addr;
  logic [N*LW-1:0] s_cmd_len;
  logic            m_cmd_valid;
  logic            m_cmd_ready;
  logic [AW-1:0]   m_cmd_addr;
  logic [LW-1:0]   m_cmd_len;
  logic            s_data_valid;
  logic            s_data_ready;
  logic [511:0]    s_data_data;
  logic [63:0]     s_data_keep;
  logic            s_data_last;
  logic [N-1:0]    m_data_valid;
  logic [N-1:0]    m_data_ready;
  logic [511:0]    m_data_data;
  logic [63:0]     m_data_keep;
  logic            m_data_last;
  logic [4:0]      outstanding;
  logic [31:0]     zero_len_drops;

  dma_cmd_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (MAXO),
    .ADDR_W          (AW),
    .LEN_W           (LW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_cmd_valid    (s_cmd_valid),
    .s_cmd_ready    (s_cmd_ready),
    .s_cmd_addr     (s_cmd_addr),
    .s_cmd_len      (s_cmd_len),
    .m_cmd_valid    (m_cmd_valid),
    .m_cmd_ready    (m_cmd_ready),
    .m_cmd_addr     (m_cmd_addr),
    .m_cmd_len      (m_cmd_len),
    .s_data_valid   (s_data_valid),
    .s_data_ready   (s_data_ready),
    .s_data_data    (s_data_data),
    .s_data_keep    (s_data_keep),
    .s_data_last    (s_data_last),
    .m_data_valid   (m_data_valid),
    .m_data_ready   (m_data_ready),
    .m_data_data    (m_data_data),
    .m_data_keep    (m_data_keep),
    .m_data_last    (m_data_last),
    .outstanding    (outstanding),
    .zero_len_drops (zero_len_drops)
  );

  always #5 aclk = ~aclk;

  // Reference model: owners of outstanding commands, beats per
  // command the DMA still has to return, and the output slot.
  int          tagq[$];
  int          dmaq[$];
  int          rr;
  bit          mv;
  logic [63:0] ma;
  logic [31:0] ml;
  logic [31:0] drops;
  int          beat;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic reset_model();
    tagq.delete();
    dmaq.delete();
    rr    = 0;
    mv    = 1'b0;
    ma    = '0;
    ml    = '0;
    drops = '0;
    beat  = 0;
  endtask

  function automatic int beats_of(input logic [31:0] len);
    return (int'(len) + 63) / 64;
  endfunction

  task automatic model_arb(output bit g, output int w);
    bit ld;
    g  = 1'b0;
    w  = 0;
    ld = !areset && (!mv || m_cmd_ready) && tagq.size() < MAXO;
    if (ld) begin
      for (int k = 1; k <= N; k++) begin
        int j = (rr + k) % N;
        if (!g && s_cmd_valid[j]) begin
          g = 1'b1;
          w = j;
        end
      end
    end
  endtask

  task automatic compare();
    bit           g;
    int           w;
    logic [N-1:0] er;
    logic [N-1:0] edv;
    bit           esr;
    model_arb(g, w);
    er = '0;
    if (g) er[w] = 1'b1;
    chk("s_cmd_ready", s_cmd_ready, er);
    chk("m_cmd_valid", m_cmd_valid, mv);
    chk("m_cmd_addr", m_cmd_addr, ma);
    chk("m_cmd_len", m_cmd_len, ml);
    chk("outstanding", outstanding, tagq.size());
    chk("zero_len_drops", zero_len_drops, drops);
    edv = '0;
    esr = 1'b0;
    if (tagq.size() > 0) begin
      if (s_data_valid) edv[tagq[0]] = 1'b1;
      esr = m_data_ready[tagq[0]];
    end
    chk("m_data_valid", m_data_valid, edv);
    chk("s_data_ready", s_data_ready, esr);
    if (s_data_valid) begin
      chk("m_data_data", m_data_data, s_data_data);
      chk("m_data_keep", m_data_keep, s_data_keep);
      chk("m_data_last", m_data_last, s_data_last);
    end
  endtask

  task automatic update();
    bit g;
    int w;
    bit hs;
    bit dpop;
    if (areset) begin
      reset_model();
      return;
    end
    model_arb(g, w);
    hs   = mv && m_cmd_ready;
    dpop = s_data_valid && tagq.size() > 0
        && m_data_ready[tagq[0]];
    if (dpop) begin
      beat++;
      if (s_data_last) begin
        void'(tagq.pop_front());
        if (dmaq.size() > 0) void'(dmaq.pop_front());
        beat = 0;
      end
    end
    if (hs) begin
      dmaq.push_back(beats_of(ml));
      mv = 1'b0;
    end
    if (g) begin
      rr = w;
      if (s_cmd_len[w*LW +: LW] == '0) begin
        if (drops != 32'hFFFF_FFFF) drops = drops + 1;
      end else begin
        tagq.push_back(w);
        mv = 1'b1;
        ma = s_cmd_addr[w*AW +: AW];
        ml = s_cmd_len[w*LW +: LW];
      end
    end
  endtask

  // Inputs are applied at the falling edge; outputs are
  // compared 1ns later, well before the rising edge.
  task automatic step();
    #1;
    compare();
    update();
    @(negedge aclk);
  endtask

  task automatic drv_data(input int p);
    if (dmaq.size() > 0 && ($urandom % 100) < p) begin
      s_data_valid = 1'b1;
      s_data_last  = (beat >= dmaq[0] - 1);
      for (int i = 0; i < 16; i++) begin
        s_data_data[i*32 +: 32] = $urandom;
      end
      s_data_keep = {$urandom, $urandom};
    end else begin
      s_data_valid = 1'b0;
      s_data_last  = 1'b0;
    end
  endtask

  task automatic drive(input int pv, input int pz, input int pmr,
                       input int pdv, input int pdr,
                       input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      s_cmd_valid[i] = mask[i] && (($urandom % 100) < pv);
      s_cmd_addr[i*AW +: AW] = {$urandom, $urandom};
      if (($urandom % 100) < pz) s_cmd_len[i*LW +: LW] = '0;
      else s_cmd_len[i*LW +: LW] = $urandom_range(256, 1);
      m_data_ready[i] = ($urandom % 100) < pdr;
    end
    m_cmd_ready = ($urandom % 100) < pmr;
    drv_data(pdv);
  endtask

  task automatic drain();
    for (int c = 0; c < 600; c++) begin
      if (tagq.size() == 0 && dmaq.size() == 0 && !mv) break;
      drive(0, 0, 100, 100, 100, '0);
      step();
    end
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    chk("drain_outstanding", outstanding, 0);
    chk("drain_m_cmd_valid", m_cmd_valid, 0);
  endtask

  initial begin
    areset       = 1'b1;
    s_cmd_valid  = '0;
    s_cmd_addr   = '0;
    s_cmd_len    = '0;
    m_cmd_ready  = 1'b0;
    s_data_valid = 1'b0;
    s_data_data  = '0;
    s_data_keep  = '0;
    s_data_last  = 1'b0;
    m_data_ready = '1;
    reset_model();
    @(negedge aclk);
    step();
    step();
    areset = 1'b0;
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_outstanding", outstanding, 0);

    // Single requester 1, 128 bytes -> two beats.
    s_cmd_valid = 4'b0010;
    s_cmd_addr[1*AW +: AW] = 64'h1000;
    s_cmd_len[1*LW +: LW]  = 32'd128;
    step();
    s_cmd_valid = '0;
    m_cmd_ready = 1'b1;
    chk("t1_m_cmd_valid", m_cmd_valid, 1);
    chk("t1_m_cmd_addr", m_cmd_addr, 64'h1000);
    chk("t1_m_cmd_len", m_cmd_len, 32'd128);
    chk("t1_outstanding", outstanding, 1);
    step();
    m_cmd_ready = 1'b0;
    drv_data(100);
    #1 chk("t1_beat0_route", m_data_valid, 4'b0010);
    step();
    drv_data(100);
    #1 chk("t1_beat1_last", m_data_last, 1);
    step();
    s_data_valid = 1'b0;
    chk("t1_done_outstanding", outstanding, 0);

    // Zero-length command from requester 3.
    s_cmd_valid = 4'b1000;
    s_cmd_len[3*LW +: LW] = '0;
    m_cmd_ready = 1'b1;
    #1 chk("zl_ready", s_cmd_ready, 4'b1000);
    step();
    s_cmd_valid = '0;
    chk("zl_no_cmd", m_cmd_valid, 0);
    chk("zl_drops", zero_len_drops, 1);
    chk("zl_outstanding", outstanding, 0);
    step();

    // Fill the tag FIFO with no data returning.
    s_cmd_valid = 4'b0001;
    s_cmd_len[0*LW +: LW] = 32'd64;
    m_cmd_ready = 1'b1;
    repeat (MAXO) step();
    chk("full_outstanding", outstanding, 16);
    #1 chk("full_blocked", s_cmd_ready, 4'b0000);
    step();
    drv_data(100);
    step();
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    #1 chk("full_resume", s_cmd_ready, 4'b0001);
    chk("full_after_pop", outstanding, 15);
    step();
    s_cmd_valid = '0;
    drain();

    // Requester 2 stalls mid-burst with requester 0 queued behind.
    s_cmd_valid = 4'b0100;
    s_cmd_len[2*LW +: LW] = 32'd256;
    step();
    s_cmd_valid = 4'b0001;
    s_cmd_len[0*LW +: LW] = 32'd64;
    step();
    s_cmd_valid = '0;
    step();
    for (int c = 0; c < 10; c++) begin
      drv_data(100);
      m_data_ready = (c >= 2 && c <= 4) ? 4'b1011 : 4'b1111;
      if (c == 3) begin
        #1 chk("stall_s_data_ready", s_data_ready, 0);
        chk("stall_blocks_req0", m_data_valid, 4'b0100);
      end
      step();
    end
    m_data_ready = '1;
    drain();

    // Asynchronous reset with commands in flight.
    s_cmd_valid = 4'b0001;
    s_cmd_len[0*LW +: LW] = 32'd64;
    m_cmd_ready = 1'b1;
    s_data_valid = 1'b0;
    repeat (5) step();
    chk("pre_rst_outstanding", outstanding, 5);
    chk("pre_rst_m_cmd_valid", m_cmd_valid, 1);
    #2 areset = 1'b1;
    #1;
    chk("async_m_cmd_valid", m_cmd_valid, 0);
    chk("async_outstanding", outstanding, 0);
    chk("async_s_cmd_ready", s_cmd_ready, 0);
    reset_model();
    @(negedge aclk);
    areset = 1'b0;
    s_cmd_valid = '1;
    for (int i = 0; i < N; i++) s_cmd_len[i*LW +: LW] = 32'd64;
    #1 chk("rst_first_grant", s_cmd_ready, 4'b0010);
    step();

    // All requesters valid: rotating grants, random returns.
    for (int c = 0; c < 24; c++) begin
      drive(100, 0, 100, 80, 100, '1);
      step();
    end
    drain();

    // Fully randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive(60, 10, 70, 70, 75, '1);
      step();
    end
    s_cmd_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
